tpu_sequencer: RTL

Run controller for one matrix pass of the 32x32 TPU. On a start pulse it pops one weight tile from the weight FIFO and holds weight reload so the array latches the tile. It then streams a programmable run of unified-buffer rows into the data-setup path. It writes each result row into the results SRAM after the fixed array pipeline latency, and reports completion. It replaces the free-running counter/state-count glue around the systolic datapath.

---
 rtl/tpu_sequencer_if.sv | 31 +++
 rtl/tpu_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tpu_sequencer_if.sv
// Handshake bundle between the matrix-pass run controller and its host and datapath.
// The host drives the start request, run configuration and FIFO status. The controller drives the datapath strobes.
interface tpu_sequencer_if #(
    parameter int ADDRESSSIZE = 10
);
    logic                   start;
    logic [ADDRESSSIZE-1:0] cfg_ub_base;
    logic [ADDRESSSIZE-1:0] cfg_res_base;
    logic [ADDRESSSIZE-1:0] cfg_len;
    logic                   fifo_empty;
    logic                   fifo_read_enable;
    logic                   we_rl;
    logic [ADDRESSSIZE-1:0] ub_address;
    logic                   ub_valid;
    logic                   res_write_enable;
    logic [ADDRESSSIZE-1:0] res_address;
    logic                   busy;
    logic                   done;

    modport master (
        output start, cfg_ub_base, cfg_res_base, cfg_len, fifo_empty,
        input  fifo_read_enable, we_rl, ub_address, ub_valid,
               res_write_enable, res_address, busy, done
    );

    modport slave (
        input  start, cfg_ub_base, cfg_res_base, cfg_len, fifo_empty,
        output fifo_read_enable, we_rl, ub_address, ub_valid,
               res_write_enable, res_address, busy, done
    );
endinterface

// File: rtl/tpu_sequencer.sv
// Run controller for one matrix pass: weight tile load, unified-buffer row streaming,
// delayed result-row writes into the results SRAM, and a completion pulse.
module tpu_sequencer #(
    parameter int ADDRESSSIZE = 10,
    parameter int W_LAT       = 2,
    parameter int RES_LAT     = 66
) (
    input  logic           clk,
    input  logic           rst,
    tpu_sequencer_if.slave bus
);
    localparam int WLW = (W_LAT > 1) ? $clog2(W_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        WLOAD  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t                 state_r;
    logic [ADDRESSSIZE-1:0] ub_base_r;
    logic [ADDRESSSIZE-1:0] res_base_r;
    logic [ADDRESSSIZE-1:0] len_r;
    logic [ADDRESSSIZE-1:0] icount_r;
    logic [ADDRESSSIZE-1:0] wcount_r;
    logic [ADDRESSSIZE-1:0] ub_address_r;
    logic [ADDRESSSIZE-1:0] res_address_r;
    logic [WLW-1:0]         wl_cnt_r;
    logic                   we_rl_r;
    logic                   ub_valid_r;
    logic                   res_we_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   pre_we_s;
    logic                   pop_s;
    logic                   accept_s;

    // Pop is the single output that must react in the same cycle the FIFO reports data.
    always_comb begin
        pop_s    = (state_r == WAIT_W) && !bus.fifo_empty;
        accept_s = (state_r == IDLE) && bus.start && (bus.cfg_len != {ADDRESSSIZE{1'b0}});
    end

    // Delay line of ub_valid. pre_we_s is asserted one cycle before the matching write,
    // so the write strobe and its address can both leave from flops.
    generate
        if (RES_LAT == 1) begin : g_nodl
            assign pre_we_s = ub_valid_r;
        end else if (RES_LAT == 2) begin : g_dl1
            logic dl_r;
            // Single-stage delay of the row-valid flag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_r <= 1'b0;
                end else begin
                    dl_r <= ub_valid_r;
                end
            end
            assign pre_we_s = dl_r;
        end else begin : g_dln
            logic [RES_LAT-2:0] dl_r;
            // Multi-stage shift of the row-valid flag through the array latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_r <= {(RES_LAT-1){1'b0}};
                end else begin
                    dl_r <= {dl_r[RES_LAT-3:0], ub_valid_r};
                end
            end
            assign pre_we_s = dl_r[RES_LAT-2];
        end
    endgenerate

    // Result write port: strobe, address and the completed-write counter j.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_we_r      <= 1'b0;
            res_address_r <= {ADDRESSSIZE{1'b0}};
            wcount_r      <= {ADDRESSSIZE{1'b0}};
        end else begin
            res_we_r      <= pre_we_s;
            res_address_r <= pre_we_s ? (res_base_r + wcount_r) : {ADDRESSSIZE{1'b0}};
            if (accept_s) begin
                wcount_r <= {ADDRESSSIZE{1'b0}};
            end else if (pre_we_s) begin
                wcount_r <= wcount_r + ADDRESSSIZE'(1);
            end else begin
                wcount_r <= wcount_r;
            end
        end
    end

    // Run state machine with registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            ub_base_r    <= {ADDRESSSIZE{1'b0}};
            res_base_r   <= {ADDRESSSIZE{1'b0}};
            len_r        <= {ADDRESSSIZE{1'b0}};
            icount_r     <= {ADDRESSSIZE{1'b0}};
            ub_address_r <= {ADDRESSSIZE{1'b0}};
            wl_cnt_r     <= {WLW{1'b0}};
            we_rl_r      <= 1'b0;
            ub_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ub_base_r  <= bus.cfg_ub_base;
                        res_base_r <= bus.cfg_res_base;
                        len_r      <= bus.cfg_len;
                        busy_r     <= 1'b1;
                        state_r    <= WAIT_W;
                    end else if (bus.start) begin
                        done_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_W: begin
                    if (pop_s) begin
                        we_rl_r  <= 1'b1;
                        wl_cnt_r <= {WLW{1'b0}};
                        state_r  <= WLOAD;
                    end else begin
                        state_r <= WAIT_W;
                    end
                end
                WLOAD: begin
                    if (wl_cnt_r == WLW'(W_LAT - 1)) begin
                        we_rl_r      <= 1'b0;
                        ub_valid_r   <= 1'b1;
                        ub_address_r <= ub_base_r;
                        icount_r     <= ADDRESSSIZE'(1);
                        state_r      <= STREAM;
                    end else begin
                        wl_cnt_r <= wl_cnt_r + WLW'(1);
                    end
                end
                STREAM: begin
                    // Address addition wraps silently at the top of the buffer.
                    if (icount_r == len_r) begin
                        ub_valid_r   <= 1'b0;
                        ub_address_r <= {ADDRESSSIZE{1'b0}};
                        state_r      <= DRAIN;
                    end else begin
                        ub_address_r <= ub_base_r + icount_r;
                        icount_r     <= icount_r + ADDRESSSIZE'(1);
                    end
                end
                DRAIN: begin
                    if (wcount_r == len_r) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    we_rl_r      <= 1'b0;
                    ub_valid_r   <= 1'b0;
                    ub_address_r <= {ADDRESSSIZE{1'b0}};
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_read_enable = pop_s;
    assign bus.we_rl            = we_rl_r;
    assign bus.ub_address       = ub_address_r;
    assign bus.ub_valid         = ub_valid_r;
    assign bus.res_write_enable = res_we_r;
    assign bus.res_address      = res_address_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
endmodule
